md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers, in the EX stage of the pipelined mips core, beside the ALU.
- EX drives start, opcode and operands. The unit raises busy while it computes; the hazard unit stalls later HI/LO users on busy.
- Results commit to HI/LO after a fixed latency. MTHI/MTLO write HI/LO in one cycle.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >= 1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  EX holds a valid md instruction this cycle.
- md_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
- src_a  input  32  rs operand; also the MTHI/MTLO data.
- src_b  input  32  rt operand.
- busy  output  1  operation in flight.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- One clock, clk. Reset is asynchronous and active-high.
- While reset is high: busy=0, hi=0, lo=0, counter=0, pending result cleared.
- Reset mid-operation aborts the operation; no HI/LO write ever occurs for it.
- States: IDLE (counter==0) and RUN (counter!=0). busy = (counter != 0), driven from the register only, no combinational path from start.
- IDLE, rising edge with start=1 and md_op in 0-3:
  - Latch op/src_a/src_b, or the computed 64-bit result.
  - Load counter with MULT_CYCLES (ops 0-1) or DIV_CYCLES (ops 2-3).
  - Enter RUN.
- IDLE, rising edge with start=1 and md_op=4: hi<=src_a. With md_op=5: lo<=src_a. busy stays 0.
- IDLE, start=1 with md_op 6-7: no effect.
- RUN, each edge: counter decrements.
  - On the edge where counter goes 1->0, commit the pending result to hi/lo and return to IDLE.
  - Net timing: start sampled at edge t -> busy high after edges t..t+N-1 -> hi/lo updated and busy low after edge t+N.
- start while busy=1, any md_op: ignored; no restart, no MTHI/MTLO write. The hazard unit must not issue in this case; the unit tolerates it.
- A new start is accepted on the first edge where busy=0 (back-to-back issue is allowed).
- hi/lo are read combinationally from the registers. Before commit they hold old values; they never show partial results.
- MULT: signed 32x32 -> 64-bit; hi = upper word, lo = lower word.
- MULTU: same, operands unsigned.
- DIV: signed; lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU: unsigned quotient (lo) and remainder (hi).
- src_b==0 for DIV/DIVU: busy still runs DIV_CYCLES; hi/lo left unchanged at commit.
- Operands are captured at the start edge. Changes to src_a/src_b during RUN do not affect the result.

Test Plan:
- Reset, then MULT src_a=0xFFFFFFFF src_b=0x00000002 -> busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE; hi/lo = 0 before commit.
- MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- DIV src_a=0xFFFFFFF9 (-7) src_b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Then DIVU 7/2 on the first edge where busy=0 -> lo=3, hi=1.
- MTHI src_a=0x00001234, then MTLO src_a=0x00005678 on consecutive cycles -> hi=0x1234 and lo=0x5678 each one edge later; busy never asserts.
- During a DIV, assert start with MULT 3*4 and MTLO 0xDEAD -> ignored; the DIV result commits at cycle 10; lo never equals 0xDEAD or 12.
- DIV by zero with hi=0x1234, lo=0x5678 preset -> busy for 10 cycles; hi/lo unchanged.
  - Then start MULT, assert reset at cycle 3 -> busy=0, hi=lo=0 immediately (asynchronous); no later commit.

Source files
------------

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Results are computed at issue, held pending, and committed after a fixed latency.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned DW         = 32;
  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_n;
  logic [CW-1:0]       cnt_q, cnt_n;
  logic [DW-1:0]       hi_q, hi_n, lo_q, lo_n;
  logic [2*DW-1:0]     res_q, res_n, res_c;
  logic                wr_q, wr_n, wr_c;
  logic signed [DW-1:0] sq, sr;

  // Full result for the operation presented this cycle; captured only at issue.
  always_comb begin
    res_c = '0;
    wr_c  = 1'b1;
    sq    = '0;
    sr    = '0;
    case (md_op)
      OP_MULT:  res_c = $signed({{DW{src_a[DW-1]}}, src_a}) * $signed({{DW{src_b[DW-1]}}, src_b});
      OP_MULTU: res_c = {{DW{1'b0}}, src_a} * {{DW{1'b0}}, src_b};
      OP_DIV: begin
        if (src_b == '0) begin
          wr_c = 1'b0;
        end else if (src_a == 32'h8000_0000 && src_b == 32'hFFFF_FFFF) begin
          // Quotient overflows; architecturally wraps to the dividend.
          res_c = {32'h0000_0000, 32'h8000_0000};
        end else begin
          sq    = $signed(src_a) / $signed(src_b);
          sr    = $signed(src_a) % $signed(src_b);
          res_c = {sr, sq};
        end
      end
      OP_DIVU: begin
        if (src_b == '0) wr_c = 1'b0;
        else             res_c = {src_a % src_b, src_a / src_b};
      end
      default: ;
    endcase
  end

  // Next-state: issue from IDLE, count down in RUN, commit on the last count.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    hi_n    = hi_q;
    lo_n    = lo_q;
    res_n   = res_q;
    wr_n    = wr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT, OP_MULTU: begin
              res_n   = res_c;
              wr_n    = 1'b1;
              cnt_n   = CW'(MULT_CYCLES);
              state_n = RUN;
            end
            OP_DIV, OP_DIVU: begin
              res_n   = res_c;
              wr_n    = wr_c;
              cnt_n   = CW'(DIV_CYCLES);
              state_n = RUN;
            end
            OP_MTHI: hi_n = src_a;
            OP_MTLO: lo_n = src_a;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_n = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_n = IDLE;
          if (wr_q) begin
            hi_n = res_q[2*DW-1:DW];
            lo_n = res_q[DW-1:0];
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      wr_q    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      hi_q    <= hi_n;
      lo_q    <= lo_n;
      res_q   <= res_n;
      wr_q    <= wr_n;
      busy    <= (state_n == RUN);
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed testbench for md_unit: per-cycle comparison against an arithmetic
// model of HI/LO/busy plus hand-computed expectations.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a, src_b;
  logic        busy;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: result computed with 64-bit integer arithmetic.
  task automatic model_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [63:0] res, output bit wr);
    int              ia, ib;
    longint          sp, q, r;
    longint unsigned ua, ub, up;
    ia = a; ib = b;
    ua = 64'(a); ub = 64'(b);
    res = '0; wr = 1'b1;
    case (op)
      3'd0: begin sp = longint'(ia) * longint'(ib); res = sp; end
      3'd1: begin up = ua * ub; res = up; end
      3'd2: if (b == 0) wr = 1'b0;
            else begin
              q = longint'(ia) / longint'(ib);
              r = longint'(ia) % longint'(ib);
              res = {r[31:0], q[31:0]};
            end
      3'd3: if (b == 0) wr = 1'b0;
            else begin
              q = longint'(ua / ub);
              r = longint'(ua % ub);
              res = {r[31:0], q[31:0]};
            end
      default: wr = 1'b0;
    endcase
  endtask

  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  bit          m_wr;
  int          m_left;

  always @(posedge clk or posedge reset) begin
    logic [63:0] r;
    bit          w;
    if (reset) begin
      m_hi <= '0; m_lo <= '0; m_left <= 0; m_wr <= 1'b0; m_res <= '0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1 && m_wr) begin
        m_hi <= m_res[63:32];
        m_lo <= m_res[31:0];
      end
    end else if (start) begin
      if (md_op <= 3'd3) begin
        model_calc(md_op, src_a, src_b, r, w);
        m_res  <= r;
        m_wr   <= w;
        m_left <= (md_op <= 3'd1) ? 5 : 10;
      end else if (md_op == 3'd4) begin
        m_hi <= src_a;
      end else if (md_op == 3'd5) begin
        m_lo <= src_a;
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("cyc_busy", 32'(busy), 32'(m_left != 0));
    chk("cyc_hi", hi, m_hi);
    chk("cyc_lo", lo, m_lo);
  end

  // Present an op for one edge; called and returns on a falling edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; md_op = 3'd7;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, ehi, elo;
    int          cyc;
  } vec_t;

  vec_t vecs[4];
  int   n;

  initial begin
    vecs[0] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
    vecs[1] = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
    vecs[2] = '{3'd3, 32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 32'h1999_9999, 10};
    vecs[3] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};

    reset = 1'b1; start = 1'b0; md_op = 3'd7; src_a = '0; src_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // MULT -1 * 2
    issue(3'd0, 32'hFFFF_FFFF, 32'h0000_0002);
    chk("mult_pre_hi", hi, 32'd0);
    chk("mult_pre_lo", lo, 32'd0);
    wait_idle(n);
    chk("mult_cycles", 32'(n), 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);

    // MULTU same operands, back to back
    issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_idle(n);
    chk("multu_cycles", 32'(n), 32'd5);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // DIV -7 / 2 then DIVU 7 / 2 on the first idle edge
    issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_idle(n);
    chk("div_cycles", 32'(n), 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    issue(3'd3, 32'h0000_0007, 32'h0000_0002);
    wait_idle(n);
    chk("divu_cycles", 32'(n), 32'd10);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    // MTHI then MTLO on consecutive cycles
    issue(3'd4, 32'h0000_1234, 32'h0);
    chk("mthi_hi", hi, 32'h0000_1234);
    chk("mthi_busy", 32'(busy), 32'd0);
    issue(3'd5, 32'h0000_5678, 32'h0);
    chk("mtlo_lo", lo, 32'h0000_5678);
    chk("mtlo_busy", 32'(busy), 32'd0);

    // Starts during a DIV are ignored; operands change mid-run
    issue(3'd2, 32'd100, 32'd7);
    start = 1'b1; md_op = 3'd0; src_a = 32'd3; src_b = 32'd4;
    @(negedge clk);
    md_op = 3'd5; src_a = 32'h0000_DEAD;
    @(negedge clk);
    start = 1'b0; md_op = 3'd7; src_a = 32'hFFFF_0000; src_b = 32'd1;
    wait_idle(n);
    chk("ign_cycles", 32'(n), 32'd8);
    chk("ign_lo", lo, 32'd14);
    chk("ign_hi", hi, 32'd2);

    // Directed vector table
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_idle(n);
      chk($sformatf("vec%0d_cycles", i), 32'(n), 32'(vecs[i].cyc));
      chk($sformatf("vec%0d_hi", i), hi, vecs[i].ehi);
      chk($sformatf("vec%0d_lo", i), lo, vecs[i].elo);
    end

    // Divide by zero leaves preset HI/LO intact
    issue(3'd4, 32'h0000_1234, 32'h0);
    issue(3'd5, 32'h0000_5678, 32'h0);
    issue(3'd2, 32'd55, 32'd0);
    wait_idle(n);
    chk("dz_cycles", 32'(n), 32'd10);
    chk("dz_hi", hi, 32'h0000_1234);
    chk("dz_lo", lo, 32'h0000_5678);
    issue(3'd3, 32'd55, 32'd0);
    wait_idle(n);
    chk("dzu_cycles", 32'(n), 32'd10);
    chk("dzu_lo", lo, 32'h0000_5678);

    // Reset mid-MULT clears immediately and no commit follows
    issue(3'd0, 32'd3, 32'd4);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_hi", hi, 32'd0);
    chk("post_lo", lo, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
